// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store unit.
//   size_e  - access size encoding (raw 2'b11 decodes to SZ_WORD)
//   state_e - controller FSM states
//   req_t   - registered request payload
package lsu_pkg;

  localparam int unsigned LSU_DW = 32;
  localparam int unsigned LSU_AW = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC0 = 2'b01,
    ACC1 = 2'b10,
    RESP = 2'b11
  } state_e;

  typedef struct packed {
    logic              we;
    size_e             size;
    logic              uns;
    logic [LSU_AW-1:0] addr;
    logic [LSU_DW-1:0] wdata;
  } req_t;

  // Raw core size field to enum; the reserved code behaves as a word.
  function automatic size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: core request/response and memory port bundle of the LSU.
//   slave  - LSU side: takes req_*/mem_data_out, drives req_ready, rsp_*, mem_*
//   master - core + memory side (the opposite directions)
interface lsu_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned ADDR_WIDTH = lsu_pkg::LSU_AW;
  localparam int unsigned MASK_SIZE  = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  mem_write_en;
  logic [MASK_SIZE-1:0]  mem_mask;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_write_en, mem_mask, mem_addr, mem_data_in
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_write_en, mem_mask, mem_addr, mem_data_in
  );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the LSU.
//   size_i/uns_i/off_i - access size, zero-extend flag, byte offset
//   hi_sel_i           - 0: first (low) word of the access, 1: spill word
//   wdata_i            - right-justified store data
//   rd_lo_i/rd_hi_i    - memory words at A and A+4 (rd_hi_i=0 if unused)
//   misaligned_c_o     - access crosses a word boundary
//   mask_c_o/wdata_c_o - byte enables and lane-aligned data for hi_sel_i word
//   rdata_c_o          - extracted, sign/zero-extended load data
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  input  logic        hi_sel_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rd_lo_i,
  input  logic [31:0] rd_hi_i,
  output logic        misaligned_c_o,
  output logic [3:0]  mask_c_o,
  output logic [31:0] wdata_c_o,
  output logic [31:0] rdata_c_o
);

  logic [7:0]  base_mask;
  logic [7:0]  mask_span;
  logic [63:0] wdata_span;
  logic [31:0] rd_shift;
  logic [4:0]  sh;

  // Work on a two-word span so bytes past lane 3 land in the spill word.
  always_comb begin
    sh = {off_i, 3'b000};
    case (size_i)
      SZ_BYTE: base_mask = 8'b0000_0001;
      SZ_HALF: base_mask = 8'b0000_0011;
      default: base_mask = 8'b0000_1111;
    endcase
    mask_span  = base_mask << off_i;
    wdata_span = 64'(wdata_i) << sh;
    mask_c_o   = hi_sel_i ? mask_span[7:4]    : mask_span[3:0];
    wdata_c_o  = hi_sel_i ? wdata_span[63:32] : wdata_span[31:0];

    misaligned_c_o = ((size_i == SZ_HALF) && (off_i == 2'd3)) ||
                     ((size_i == SZ_WORD) && (off_i != 2'd0));

    rd_shift = 32'({rd_hi_i, rd_lo_i} >> sh);
    case (size_i)
      SZ_BYTE: rdata_c_o = {{24{~uns_i & rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: rdata_c_o = {{16{~uns_i & rd_shift[15]}}, rd_shift[15:0]};
      default: rdata_c_o = rd_shift;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between a core request port and a
// single-cycle memory.
//   clk    - clock, rising edge
//   arst_n - asynchronous active-low reset
//   bus    - lsu_if.slave: core request/response and memory port
// Build option: LSU_MISALIGNED_EN splits word-crossing accesses into two
// memory cycles; without it such requests are answered with rsp_err.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic  clk,
  input logic  arst_n,
  lsu_if.slave bus
);

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned MASK_SIZE  = DATA_WIDTH / 8;

  state_e                state_q, state_d;
  req_t                  req_q, req_d, req_in;
  logic [DATA_WIDTH-1:0] rd_lo_q, rd_lo_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  mem_we_q, mem_we_d;
  logic [MASK_SIZE-1:0]  mem_mask_q, mem_mask_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  a_misaligned;
  logic [MASK_SIZE-1:0]  a_mask;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic [DATA_WIDTH-1:0] a_rd_lo;
  logic [DATA_WIDTH-1:0] a_rd_hi;

  // Lane logic sees the incoming request in IDLE so ACC0 outputs can be registered.
  always_comb begin
    if (state_q == IDLE) begin
      req_in.we    = bus.req_we;
      req_in.size  = decode_size(bus.req_size);
      req_in.uns   = bus.req_unsigned;
      req_in.addr  = bus.req_addr;
      req_in.wdata = bus.req_wdata;
    end else begin
      req_in = req_q;
    end
    a_rd_lo = (state_q == ACC1) ? rd_lo_q : bus.mem_data_out;
    a_rd_hi = (state_q == ACC1) ? bus.mem_data_out : '0;
  end

  lsu_align u_align (
    .size_i         (req_in.size),
    .uns_i          (req_in.uns),
    .off_i          (req_in.addr[1:0]),
    .hi_sel_i       (state_q == ACC0),
    .wdata_i        (req_in.wdata),
    .rd_lo_i        (a_rd_lo),
    .rd_hi_i        (a_rd_hi),
    .misaligned_c_o (a_misaligned),
    .mask_c_o       (a_mask),
    .wdata_c_o      (a_wdata),
    .rdata_c_o      (a_rdata)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rd_lo_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_mask_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rd_lo_q     <= rd_lo_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_we_q    <= mem_we_d;
      mem_mask_q  <= mem_mask_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next state plus the output values that go with it.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rd_lo_d     = rd_lo_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_mask_d  = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d       = req_in;
          state_d     = ACC0;
          mem_we_d    = req_in.we;
          mem_mask_d  = a_mask;
          mem_addr_d  = {req_in.addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_d = a_wdata;
`ifndef LSU_MISALIGNED_EN
          // Reject without touching memory.
          if (a_misaligned) begin
            state_d     = RESP;
            mem_we_d    = 1'b0;
            mem_mask_d  = '0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
`endif
        end
      end
      ACC0: begin
        rd_lo_d = bus.mem_data_out;
`ifdef LSU_MISALIGNED_EN
        if (a_misaligned) begin
          // Spill into the next word; address wraps at the top of memory.
          state_d     = ACC1;
          mem_we_d    = req_q.we;
          mem_mask_d  = a_mask;
          mem_addr_d  = {req_q.addr[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(1), 2'b00};
          mem_wdata_d = a_wdata;
        end else
`endif
        begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = req_q.we ? '0 : a_rdata;
        end
      end
      ACC1: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = req_q.we ? '0 : a_rdata;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  assign bus.req_ready    = ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.mem_write_en = mem_we_q;
  assign bus.mem_mask     = mem_mask_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_in  = mem_wdata_q;

endmodule
